// File: rtl/horizon_pkg.sv
// Shared definitions for the scrolling ground strip: state codes, geometry, terrain types.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package horizon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    typedef enum logic {
        TERRAIN_FLAT  = 1'b0,
        TERRAIN_BUMPY = 1'b1
    } terrain_t;

    localparam int HORIZON_W   = 600;
    localparam int HORIZON_TOP = 400;
    localparam int HORIZON_H   = 12;

    // 30-bit value of 'h214748364 (the digits above bit 29 fall away)
    localparam logic [29:0] RARE_THRESH = 30'h14748364;

    // Low random values are the rare (bumpy) terrain
    function automatic terrain_t terrain_of(input logic [29:0] rnd, input logic [29:0] thresh);
        return (rnd < thresh) ? TERRAIN_BUMPY : TERRAIN_FLAT;
    endfunction

endpackage

// File: rtl/terrain_fifo.sv
// Small queue of upcoming terrain types, QDEPTH entries of 1 bit each.
// Latency: push visible at dout the tick after it is written; dout is a combinational read of the head.
// Backpressure: push ignored when full, pop ignored when empty; count lets the owner throttle.
module terrain_fifo
    import horizon_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                          game_clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          din,
    output logic                          dout,
    output logic [$clog2(QDEPTH+1)-1:0]   count
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    logic [QDEPTH-1:0] mem;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && (count != CW'(QDEPTH));
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; power-of-2 depth lets the pointers wrap naturally
    always_ff @(posedge game_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid
    always_ff @(posedge game_clk) begin
        if (!rst && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/horizon_scroll_ctrl.sv
// Game-state sequencer for the ground strip: toggle column, left/right terrain, speed ramp.
// Latency: all outputs registered; start/over take effect at the sampling edge, first scroll one edge after start.
// Backpressure: none; terrain queue refills every tick while not full, an empty queue yields flat terrain.
module horizon_scroll_ctrl #(
    parameter int          HORIZON_W   = horizon_pkg::HORIZON_W,
    parameter int          SPEED_MIN   = 1,
    parameter int          SPEED_MAX   = 6,
    parameter int          RAMP_TICKS  = 1024,
    parameter int          QDEPTH      = 4,
    parameter logic [29:0] RARE_THRESH = horizon_pkg::RARE_THRESH
) (
    input  logic        game_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        over,
    input  logic [29:0] rand_val,
    output logic [9:0]  trans_col,
    output logic        terrain_l,
    output logic        terrain_r,
    output logic [2:0]  speed,
    output logic        seg_wrap,
    output logic [1:0]  state
);

    import horizon_pkg::*;

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

    state_t        state_q;
    state_t        state_d;
    logic [9:0]    col_q;
    logic          tl_q;
    logic          tr_q;
    logic [2:0]    spd_q;
    logic          wrap_q;
    logic [RW-1:0] ramp_q;

    logic [CW-1:0] q_count;
    logic          q_dout;
    logic          q_push;
    logic          q_din;

    logic          run_tick;
    logic          wrap_now;
    logic          ramp_done;
    logic          restart;
    logic [9:0]    col_wrap;

    // A RUN tick scrolls only when over is low; over wins over the scroll
    assign run_tick  = (state_q == ST_RUN) && !over;
    assign wrap_now  = run_tick && (11'(col_q) <= 11'(spd_q));
    // Wrap keeps the overshoot: 11-bit sum so col + W cannot overflow before subtracting
    assign col_wrap  = 10'(11'(col_q) + 11'(HORIZON_W) - 11'(spd_q));
    assign ramp_done = (ramp_q == RW'(RAMP_TICKS - 1));
    assign restart   = (state_q == ST_OVER) && start;

    assign q_push = (q_count < CW'(QDEPTH));
    assign q_din  = terrain_of(rand_val, RARE_THRESH);

    terrain_fifo #(
        .QDEPTH (QDEPTH)
    ) u_terrain_fifo (
        .game_clk (game_clk),
        .rst      (rst),
        .push     (q_push),
        .pop      (wrap_now),
        .din      (q_din),
        .dout     (q_dout),
        .count    (q_count)
    );

    // Game-state register
    always_ff @(posedge game_clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Game-state transitions; start is ignored in RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (over)  state_d = ST_OVER;
            ST_OVER: if (start) state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    // Scroll, segment hand-over and speed ramp; everything freezes outside RUN until restart
    always_ff @(posedge game_clk) begin
        if (rst) begin
            col_q  <= 10'(HORIZON_W);
            tl_q   <= 1'b0;
            tr_q   <= 1'b0;
            spd_q  <= 3'(SPEED_MIN);
            ramp_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_now;
            if (restart) begin
                col_q  <= 10'(HORIZON_W);
                tl_q   <= 1'b0;
                tr_q   <= 1'b0;
                spd_q  <= 3'(SPEED_MIN);
                ramp_q <= '0;
            end else if (run_tick) begin
                if (wrap_now) begin
                    col_q <= col_wrap;
                    tl_q  <= tr_q;
                    tr_q  <= (q_count != '0) ? q_dout : 1'b0;
                end else begin
                    col_q <= col_q - 10'(spd_q);
                end
                if (ramp_done) begin
                    ramp_q <= '0;
                    if (spd_q < 3'(SPEED_MAX)) spd_q <= spd_q + 3'd1;
                end else begin
                    ramp_q <= ramp_q + RW'(1);
                end
            end
        end
    end

    assign trans_col = col_q;
    assign terrain_l = tl_q;
    assign terrain_r = tr_q;
    assign speed     = spd_q;
    assign seg_wrap  = wrap_q;
    assign state     = state_q;

endmodule
